countdown_timer_ctrl: RTL

Sequencing controller for the board's counter datapath: a run/pause/expire state machine driving an internal modulo-TICK_DIV prescaler and a loadable down-counter of whole ticks. Sits between the debounced key/switch inputs and the LED/7-segment display logic, and turns the free-running prescaler-plus-counter pair into a user-controlled countdown timer. At 50 MHz with the default TICK_DIV, one tick is one second.

---
 rtl/countdown_timer_ctrl_if.sv | 25 ++
 rtl/countdown_timer_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/countdown_timer_ctrl_if.sv
// Command/status bundle between the key/switch front end and countdown_timer_ctrl.
// The master drives the command pulses and preset; the slave returns the countdown status.
interface countdown_timer_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             i_start;
  logic             i_pause;
  logic             i_clear;
  logic [CNT_W-1:0] i_preset;
  logic [CNT_W-1:0] o_remain;
  logic [1:0]       o_state;
  logic             o_tick;
  logic             o_done;
  logic             o_alarm;

  modport master (
    output i_start, i_pause, i_clear, i_preset,
    input  o_remain, o_state, o_tick, o_done, o_alarm
  );

  modport slave (
    input  i_start, i_pause, i_clear, i_preset,
    output o_remain, o_state, o_tick, o_done, o_alarm
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Run/pause/expire countdown timer: a modulo-TICK_DIV prescaler feeding a loadable tick counter.
// Optional TIMER_AUTORELOAD_EN: reload from the preset at expiry instead of latching EXPIRED.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | cleared, counter at 0, waiting for START
// ST_RUN     | prescaler advancing, REMAIN decremented on each tick
// ST_PAUSED  | prescaler and REMAIN frozen, PAUSE/START resumes
// ST_EXPIRED | countdown reached 0, ALARM asserted until CLEAR/START
module countdown_timer_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int PRE_W    = 26,
  parameter int CNT_W    = 8
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  countdown_timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_remain;
  logic [PRE_W-1:0] r_pre;

  logic w_tick;
  logic w_done;
  logic w_preset_nz;

  assign w_tick      = (r_state == ST_RUN) && (r_pre == PRE_LAST);
  assign w_done      = w_tick && (r_remain == CNT_ONE);
  assign w_preset_nz = (bus.i_preset != '0);

  // Commands are mutually exclusive per edge: CLEAR beats START beats PAUSE beats the tick.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
      r_pre    <= '0;
    end else if (bus.i_clear) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
      r_pre    <= '0;
    end else if (bus.i_start) begin
      if (r_state == ST_PAUSED) begin
        r_state <= ST_RUN;
      end else if (w_preset_nz) begin
        r_state  <= ST_RUN;
        r_remain <= bus.i_preset;
        r_pre    <= '0;
      end else begin
        r_state  <= ST_IDLE;
        r_remain <= '0;
        r_pre    <= '0;
      end
    end else if (bus.i_pause) begin
      if (r_state == ST_RUN) begin
        r_state <= ST_PAUSED;
      end else if (r_state == ST_PAUSED) begin
        r_state <= ST_RUN;
      end
    end else if (r_state == ST_RUN) begin
      if (w_done) begin
        r_pre <= '0;
`ifdef TIMER_AUTORELOAD_EN
        if (w_preset_nz) begin
          r_remain <= bus.i_preset;
        end else begin
          r_remain <= '0;
          r_state  <= ST_EXPIRED;
        end
`else
        r_remain <= '0;
        r_state  <= ST_EXPIRED;
`endif
      end else if (w_tick) begin
        r_pre    <= '0;
        r_remain <= r_remain - CNT_ONE;
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  assign bus.o_remain = r_remain;
  assign bus.o_state  = r_state;
  assign bus.o_tick   = w_tick;
  assign bus.o_done   = w_done;
  assign bus.o_alarm  = (r_state == ST_EXPIRED);

endmodule
